servo_pulse_decoder: RTL and testbench



---
 rtl/servo_pulse_decoder_pkg.sv | 23 ++
 rtl/servo_width_div.sv | 63 ++++++
 rtl/servo_pulse_decoder.sv | 164 ++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pulse_decoder_pkg.sv
// Shared servo timing constants and decoder state encoding.
// The PWM generator imports the same values so that encoding and decoding stay in step.
package servo_pulse_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } servo_state_e;

  localparam int unsigned SERVO_CLOCK_DIVIDER = 196;
  localparam int unsigned SERVO_MIN_WIDTH     = 50000;
  localparam int unsigned SERVO_MAX_WIDTH     = 120000;
  localparam int unsigned SERVO_GLITCH_WIDTH  = 16;
  localparam int unsigned SERVO_FRAME_TIMEOUT = 1000000;

  localparam int unsigned SERVO_WIDTH_W = 20;
  localparam int unsigned SERVO_POS_W   = 8;

  localparam logic [SERVO_POS_W-1:0] SERVO_POS_MAX = '1;

endpackage

// File: rtl/servo_width_div.sv
// Iterative saturating divider: one subtraction per cycle, quotient clamps at 255.
// done_o is a one-cycle strobe on the final busy cycle; quotient_o is stable from then on.
module servo_width_div
  import servo_pulse_decoder_pkg::*;
#(
  parameter int unsigned DIVISOR = SERVO_CLOCK_DIVIDER
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [SERVO_WIDTH_W-1:0] dividend_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [SERVO_POS_W-1:0]   quotient_o
);

  localparam logic [SERVO_WIDTH_W:0] DIVISOR_W = (SERVO_WIDTH_W + 1)'(DIVISOR);

  logic [SERVO_WIDTH_W:0] rem_q, rem_d;
  logic [SERVO_POS_W-1:0] quo_q, quo_d;
  logic                   busy_q, busy_d;
  logic                   stop;
  logic                   done;

  assign stop = (rem_q < DIVISOR_W) || (quo_q == SERVO_POS_MAX);

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    busy_d = busy_q;
    done   = 1'b0;
    if (start_i) begin
      rem_d  = {1'b0, dividend_i};
      quo_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (stop) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end else begin
        rem_d = rem_q - DIVISOR_W;
        quo_d = quo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done;
  assign quotient_o = quo_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse-width decoder: measures the input high time and recovers the 8-bit position.
// Define SERVO_DECODE_TIMEOUT_EN to build the frame timer that drives signal_lost.
module servo_pulse_decoder
  import servo_pulse_decoder_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDER = SERVO_CLOCK_DIVIDER,
  parameter int unsigned MIN_WIDTH     = SERVO_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH     = SERVO_MAX_WIDTH,
  parameter int unsigned GLITCH_WIDTH  = SERVO_GLITCH_WIDTH,
  parameter int unsigned FRAME_TIMEOUT = SERVO_FRAME_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pulse_in,
  output logic [SERVO_POS_W-1:0] pos,
  output logic                   pos_valid,
  output logic                   pulse_err,
  output logic                   signal_lost
);

  localparam logic [SERVO_WIDTH_W-1:0] GLITCH_W = SERVO_WIDTH_W'(GLITCH_WIDTH);
  localparam logic [SERVO_WIDTH_W-1:0] MIN_W    = SERVO_WIDTH_W'(MIN_WIDTH);
  localparam logic [SERVO_WIDTH_W-1:0] MAX_W    = SERVO_WIDTH_W'(MAX_WIDTH);
  localparam logic [SERVO_WIDTH_W-1:0] SAT_W    = SERVO_WIDTH_W'(MAX_WIDTH + 1);
  localparam logic [SERVO_WIDTH_W-1:0] OFFSET_W = SERVO_WIDTH_W'(MIN_WIDTH + 1);
  localparam logic [SERVO_WIDTH_W-1:0] HALF_W   = SERVO_WIDTH_W'(CLOCK_DIVIDER / 2);

  logic                     sync1_q, sync2_q, prev_q;
  logic [1:0]               smp_vld_q;
  logic                     armed_q, armed_d;
  logic                     rise, fall;
  servo_state_e             state_q, state_d;
  logic [SERVO_WIDTH_W-1:0] cnt_q, cnt_d;
  logic [SERVO_POS_W-1:0]   pos_q, pos_d;
  logic                     err_q, err_d;
  logic                     lost_q, lost_d;

  logic                     div_start;
  logic [SERVO_WIDTH_W-1:0] div_dividend;
  logic                     div_busy;
  logic                     div_done;
  logic [SERVO_POS_W-1:0]   div_quo;

  // After reset the synchronizer holds zeros, not real samples. Rising edges are only
  // trusted once a genuine low has been seen, so a pulse already high at release is skipped.
  assign armed_d = armed_q | (smp_vld_q[1] & ~sync2_q);
  assign rise    = sync2_q & ~prev_q & armed_q;
  assign fall    = ~sync2_q & prev_q;

  assign div_dividend = (cnt_q > MIN_W) ? (cnt_q - OFFSET_W + HALF_W) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    err_d     = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = SERVO_WIDTH_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          if (cnt_q < GLITCH_W) begin
            state_d = IDLE;
          end else if (cnt_q > MAX_W) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end else if (cnt_q != SAT_W) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV: begin
        if (div_done) begin
          pos_d   = div_quo;
          state_d = DONE;
        end else if (!div_busy) begin
          state_d = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      smp_vld_q <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pos_q     <= '0;
      err_q     <= 1'b0;
      lost_q    <= 1'b1;
    end else begin
      sync1_q   <= pulse_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      smp_vld_q <= {smp_vld_q[0], 1'b1};
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
    end
  end

  servo_width_div #(
    .DIVISOR(CLOCK_DIVIDER)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (div_start),
    .dividend_i(div_dividend),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

`ifdef SERVO_DECODE_TIMEOUT_EN
  // lost_q is registered, so it is set from the count one cycle ahead to assert
  // exactly FRAME_TIMEOUT cycles after the last pos_valid.
  localparam logic [SERVO_WIDTH_W-1:0] TIMER_LAST = SERVO_WIDTH_W'(FRAME_TIMEOUT - 1);

  logic [SERVO_WIDTH_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (pos_valid) begin
      timer_d = '0;
    end else if (timer_q < TIMER_LAST) begin
      timer_d = timer_q + 1'b1;
    end
    lost_d = ~pos_valid & (lost_q | (timer_d >= TIMER_LAST));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign lost_d = 1'b0;
`endif

  assign pos         = pos_q;
  assign pos_valid   = (state_q == DONE);
  assign pulse_err   = err_q;
  assign signal_lost = lost_q & ~pos_valid;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder using scaled timing parameters.
module tb_servo_pulse_decoder;

  localparam int CD   = 8;
  localparam int MINW = 200;
  localparam int MAXW = 2300;
  localparam int GW   = 16;
  localparam int FT   = 4000;

  localparam int K_VALID = 0;
  localparam int K_ERR   = 1;
  localparam int K_NONE  = 2;

  typedef struct {
    int width;
    int kind;
    int exp_pos;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] pos;
  logic       pos_valid;
  logic       pulse_err;
  logic       signal_lost;

  int n_checks = 0;
  int n_fail = 0;
  int pv_total = 0;
  int err_total = 0;
  int model_pos = 0;
  int exp_lost;

  vec_t vecs[14];

  always #5 clk = ~clk;

  servo_pulse_decoder #(
    .CLOCK_DIVIDER(CD),
    .MIN_WIDTH    (MINW),
    .MAX_WIDTH    (MAXW),
    .GLITCH_WIDTH (GW),
    .FRAME_TIMEOUT(FT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pulse_in   (pulse_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .pulse_err  (pulse_err),
    .signal_lost(signal_lost)
  );

  always @(negedge clk) begin
    if (pos_valid) pv_total <= pv_total + 1;
    if (pulse_err) err_total <= err_total + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One pulse of 'width' sampled-high cycles, then a 300-cycle observation window.
  task automatic run_pulse(input int width, input int kind, input int exp_pos);
    int pv0, err0, lat_pv, lat_err, sl_at_pv;
    string tag;
    tag = $sformatf("w%0d", width);
    @(negedge clk);
    #1;
    pv0  = pv_total;
    err0 = err_total;
    pulse_in = 1'b1;
    repeat (width) @(negedge clk);
    pulse_in = 1'b0;
    lat_pv   = -1;
    lat_err  = -1;
    sl_at_pv = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (pos_valid && lat_pv < 0) begin
        lat_pv   = n;
        sl_at_pv = int'(signal_lost);
      end
      if (pulse_err && lat_err < 0) lat_err = n;
    end
    @(negedge clk);
    #1;
    if (kind == K_VALID) model_pos = exp_pos;
    check({tag, "_pv_count"}, pv_total - pv0, (kind == K_VALID) ? 1 : 0);
    check({tag, "_err_count"}, err_total - err0, (kind == K_ERR) ? 1 : 0);
    check({tag, "_pos"}, int'(pos), model_pos);
    if (kind == K_VALID) begin
      check({tag, "_pv_latency"}, lat_pv, exp_pos + 4);
      check({tag, "_lost_at_pv"}, sl_at_pv, 0);
    end else if (kind == K_ERR) begin
      check({tag, "_err_latency"}, lat_err, 3);
    end
    $display("pulse width=%0d kind=%0d pos=%0d pv_lat=%0d err_lat=%0d", width, kind, pos, lat_pv, lat_err);
  endtask

  initial begin
    int pv0, err0, p_found;

    // pos = min(255, floor((w - 201 + 4) / 8)), 0 for w <= 200
    vecs[0]  = '{1001, K_VALID, 100};
    vecs[1]  = '{150,  K_VALID, 0};
    vecs[2]  = '{201,  K_VALID, 0};
    vecs[3]  = '{204,  K_VALID, 0};
    vecs[4]  = '{205,  K_VALID, 1};
    vecs[5]  = '{2600, K_ERR,   0};
    vecs[6]  = '{5,    K_NONE,  0};
    vecs[7]  = '{2241, K_VALID, 255};
    vecs[8]  = '{15,   K_NONE,  0};
    vecs[9]  = '{16,   K_VALID, 0};
    vecs[10] = '{2280, K_VALID, 255};
    vecs[11] = '{2301, K_ERR,   0};
    vecs[12] = '{2300, K_VALID, 255};
    vecs[13] = '{209,  K_VALID, 1};

    repeat (4) @(negedge clk);
    check("rst_pos", int'(pos), 0);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_pulse_err", int'(pulse_err), 0);
    check("rst_signal_lost", int'(signal_lost), 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef SERVO_DECODE_TIMEOUT_EN
    exp_lost = 1;
`else
    exp_lost = 0;
`endif
    check("post_rst_signal_lost", int'(signal_lost), exp_lost);
    $display("reset released signal_lost=%0d", signal_lost);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_pulse(vecs[i].width, vecs[i].kind, vecs[i].exp_pos);
    end

    // Second pulse arriving while the divider is still working is dropped.
    @(negedge clk);
    #1;
    pv0  = pv_total;
    err0 = err_total;
    pulse_in = 1'b1;
    repeat (2241) @(negedge clk);
    pulse_in = 1'b0;
    repeat (20) @(negedge clk);
    pulse_in = 1'b1;
    repeat (50) @(negedge clk);
    pulse_in = 1'b0;
    repeat (400) @(negedge clk);
    #1;
    model_pos = 255;
    check("busy_rise_pv_count", pv_total - pv0, 1);
    check("busy_rise_err_count", err_total - err0, 0);
    check("busy_rise_pos", int'(pos), model_pos);
    $display("rise during divide: strobes=%0d pos=%0d", pv_total - pv0, pos);
    run_pulse(1001, K_VALID, 100);

    // Reset in the middle of a pulse, released while the input is still high.
    @(negedge clk);
    #1;
    pv0  = pv_total;
    err0 = err_total;
    pulse_in = 1'b1;
    repeat (300) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_signal_lost", int'(signal_lost), 1);
    check("midrst_pos", int'(pos), 0);
    reset_n = 1'b1;
    repeat (600) @(negedge clk);
    pulse_in = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    model_pos = 0;
    check("midrst_pv_count", pv_total - pv0, 0);
    check("midrst_err_count", err_total - err0, 0);
    check("midrst_pos_after", int'(pos), model_pos);
    $display("reset mid-pulse: strobes=%0d errs=%0d pos=%0d", pv_total - pv0, err_total - err0, pos);
    run_pulse(1001, K_VALID, 100);

    // Frame timeout measured from the cycle of the last pos_valid.
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (1001) @(negedge clk);
    pulse_in = 1'b0;
    p_found = 0;
    for (int n = 1; n <= 300 && p_found == 0; n++) begin
      @(posedge clk);
      #1;
      if (pos_valid) p_found = 1;
    end
    check("to_pv_seen", p_found, 1);
    for (int k = 1; k <= FT; k++) begin
      @(posedge clk);
      #1;
      if (k == FT - 1) check("to_lost_before", int'(signal_lost), 0);
      if (k == FT) check("to_lost_at_timeout", int'(signal_lost), exp_lost);
    end
    $display("timeout window done signal_lost=%0d", signal_lost);
    run_pulse(1001, K_VALID, 100);
    check("to_lost_after_recover", int'(signal_lost), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
